vscale_csr_port_arbiter: RTL and testbench
==========================================

Name: vscale_csr_port_arbiter

Overview:
- Shares the single CSR-file access port between the core pipeline (CSRRx instructions) and the host target interface (HTIF PCR requests).
- Sits between the pipeline/HTIF and the CSR file.
- Sequences each host request as a latched, one-cycle port access followed by a response handshake.
- Gives the pipeline priority, with a bounded-wait counter that forces a host grant and stalls the core so host accesses cannot starve.

Parameters:
- MAX_WAIT, 4: maximum consecutive cycles a pending host request may lose arbitration before it is forced.
- WAIT_CNT_WIDTH, 3: width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- core_csr_valid  input  1  pipeline presents a CSR access this cycle
- core_csr_addr  input  12  pipeline CSR address
- core_csr_cmd  input  3  pipeline CSR command (READ/WRITE/SET/CLEAR/IDLE encoding from ctrl constants)
- core_csr_wdata  input  32  pipeline write operand
- core_csr_rdata  output  32  CSR read data returned to the pipeline
- core_csr_stall  output  1  pipeline must hold its CSR instruction this cycle
- htif_pcr_req_valid  input  1  host request valid
- htif_pcr_req_ready  output  1  arbiter can accept a host request
- htif_pcr_req_rw  input  1  1 = write, 0 = read
- htif_pcr_req_addr  input  12  host CSR address
- htif_pcr_req_data  input  64  host write data; only bits [31:0] are used
- htif_pcr_resp_valid  output  1  host response valid
- htif_pcr_resp_ready  input  1  host accepts the response
- htif_pcr_resp_data  output  64  response data, zero-extended from 32 bits
- csr_addr  output  12  to CSR file
- csr_cmd  output  3  to CSR file
- csr_wdata  output  32  to CSR file
- csr_rdata  input  32  combinational read data from CSR file

Behaviour:
- FSM states: IDLE, PEND, RESP. Reset forces IDLE, wait_cnt=0, latched request and resp_data cleared to 0.
- Reset mid-transaction discards the request; no response is issued.
- IDLE:
  - htif_pcr_req_ready=1.
  - On req_valid: latch rw, addr, data[31:0]; go to PEND with wait_cnt=0.
- PEND:
  - req_ready=0.
  - If core_csr_valid and wait_cnt<MAX_WAIT: core owns the port and wait_cnt increments.
  - Otherwise the host owns the port for exactly this cycle:
    - csr_addr = latched addr.
    - csr_cmd = WRITE if rw, else READ.
    - csr_wdata = latched data.
  - On a host-owned PEND cycle, csr_rdata is captured into resp_data (for writes, this is the pre-write value) and the FSM goes to RESP.
  - core_csr_stall=1 in that cycle iff core_csr_valid.
- RESP:
  - resp_valid=1; resp_data stays stable until accepted.
  - On resp_ready: go to IDLE. A new request is accepted only in the following IDLE cycle (no back-to-back overlap).
  - The port belongs to the core in RESP.
- Core-owned cycles (IDLE, RESP, PEND while not forced):
  - csr_* = core_csr_* when core_csr_valid, else csr_cmd=IDLE, csr_addr=0, csr_wdata=0.
  - core_csr_rdata = csr_rdata in every cycle; it is meaningful only when the core is not stalled.
- Stall: core_csr_stall=0 except in a forced or uncontended host PEND cycle with core_csr_valid=1.
- Latency: with an uncontended port, request accepted at cycle T, port access at T+1, resp_valid at T+2. Worst case is the access at T+1+MAX_WAIT.
- Wait counter saturates at MAX_WAIT and is cleared on leaving PEND.
- Core SET/CLEAR commands pass through unchanged; the read-modify-write stays inside the CSR file.

Decomposition:
- Shared header (alongside the ctrl constants): CSR command encodings (CSR_IDLE/READ/WRITE/SET/CLEAR), CSR_ADDR_WIDTH, CMD width, HTIF_PCR_WIDTH, and the arbiter state encodings.
- No sub-module required. The output port mux may optionally be a combinational function in the same file.

Test Plan:
- Uncontended host read of addr 0x780 while the CSR file returns 0x1234 -> ready low from T+1; csr_cmd=READ at T+1; resp_valid at T+2 with data 0x0000_0000_0000_1234.
- Host write addr 0x780, data 0xFFFF_FFFF_DEAD_BEEF, with old value 0x5 -> csr_wdata=0xDEADBEEF, cmd=WRITE for one cycle; resp_data=0x5.
- Core valid continuously with MAX_WAIT=4 and a host request pending -> core owns the port for 4 PEND cycles; 5th cycle host-owned with core_csr_stall=1; stall drops the next cycle.
- Host holds resp_ready=0 for 10 cycles -> resp_valid and data stay stable; req_ready stays 0; core accesses pass through unstalled.
- Reset asserted during PEND -> next cycle IDLE, req_ready=1, resp_valid=0, no CSR write issued.
- Back-to-back host requests with resp_ready=1 -> second request accepted the cycle after the response handshake; each response data matches its own access.

Source files
------------

// File: rtl/vscale_csr_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vscale_csr_port_arbiter_pkg
//   Shared definitions for the CSR-port arbiter: CSR command encodings that
//   match the pipeline control constants, port widths, arbiter state
//   encodings, and the packed types the arbiter uses internally.
// ---------------------------------------------------------------------------
package vscale_csr_port_arbiter_pkg;

  localparam int CSR_ADDR_WIDTH = 12;
  localparam int CSR_CMD_WIDTH  = 3;
  localparam int XPR_LEN        = 32;
  localparam int HTIF_PCR_WIDTH = 64;

  // CSR command encodings shared with the pipeline control decode.
  localparam logic [CSR_CMD_WIDTH-1:0] CSR_IDLE  = 3'd0;
  localparam logic [CSR_CMD_WIDTH-1:0] CSR_READ  = 3'd4;
  localparam logic [CSR_CMD_WIDTH-1:0] CSR_WRITE = 3'd5;
  localparam logic [CSR_CMD_WIDTH-1:0] CSR_SET   = 3'd6;
  localparam logic [CSR_CMD_WIDTH-1:0] CSR_CLEAR = 3'd7;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,  // waiting for a host request
    ARB_PEND = 2'd1,  // host request latched, waiting for the port
    ARB_RESP = 2'd2   // access done, presenting the response
  } arb_state_t;

  // Host request as latched on acceptance; only the low word of the host
  // data is ever written to a CSR.
  typedef struct packed {
    logic                      rw;
    logic [CSR_ADDR_WIDTH-1:0] addr;
    logic [XPR_LEN-1:0]        data;
  } host_req_t;

  // Everything driven toward the CSR file in one cycle.
  typedef struct packed {
    logic [CSR_ADDR_WIDTH-1:0] addr;
    logic [CSR_CMD_WIDTH-1:0]  cmd;
    logic [XPR_LEN-1:0]        wdata;
  } csr_port_t;

  localparam csr_port_t CSR_PORT_IDLE = '{addr: '0, cmd: CSR_IDLE, wdata: '0};

endpackage

// File: rtl/vscale_csr_port_arbiter.sv
// ---------------------------------------------------------------------------
// vscale_csr_port_arbiter
//   Shares the single CSR-file access port between the pipeline (CSRRx
//   instructions) and the host target interface (HTIF PCR requests).
//   The pipeline has priority; a pending host request that has lost
//   arbitration MAX_WAIT times in a row is forced onto the port and the
//   pipeline is stalled for that one cycle.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   core_csr_*            pipeline CSR access in, read data / stall out
//   htif_pcr_req_*        host request (valid/ready handshake)
//   htif_pcr_resp_*       host response (valid/ready handshake)
//   csr_addr/cmd/wdata    access port toward the CSR file
//   csr_rdata             combinational read data from the CSR file
// ---------------------------------------------------------------------------
module vscale_csr_port_arbiter
  import vscale_csr_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT       = 4,
  parameter int WAIT_CNT_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  // pipeline side
  input  logic                      core_csr_valid,
  input  logic [CSR_ADDR_WIDTH-1:0] core_csr_addr,
  input  logic [CSR_CMD_WIDTH-1:0]  core_csr_cmd,
  input  logic [XPR_LEN-1:0]        core_csr_wdata,
  output logic [XPR_LEN-1:0]        core_csr_rdata,
  output logic                      core_csr_stall,
  // host request
  input  logic                      htif_pcr_req_valid,
  output logic                      htif_pcr_req_ready,
  input  logic                      htif_pcr_req_rw,
  input  logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr,
  input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
  // host response
  output logic                      htif_pcr_resp_valid,
  input  logic                      htif_pcr_resp_ready,
  output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data,
  // CSR file port
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
  output logic [CSR_CMD_WIDTH-1:0]  csr_cmd,
  output logic [XPR_LEN-1:0]        csr_wdata,
  input  logic [XPR_LEN-1:0]        csr_rdata
);

  if (MAX_WAIT >= (1 << WAIT_CNT_WIDTH)) begin : g_bad_wait_width
    $error("WAIT_CNT_WIDTH too narrow to hold MAX_WAIT");
  end

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_MAX = WAIT_CNT_WIDTH'(MAX_WAIT);

  arb_state_t                state;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
  host_req_t                 req_q;
  logic [XPR_LEN-1:0]        resp_data_q;
  logic                      req_ready_q;
  logic                      resp_valid_q;

  logic      core_wins;
  logic      host_grant;
  csr_port_t port;

  // The upper half of the host write data is never used.
  logic unused_req_data_hi;
  assign unused_req_data_hi = ^htif_pcr_req_data[HTIF_PCR_WIDTH-1:XPR_LEN];

  // The core keeps the port in PEND until the host has waited MAX_WAIT
  // cycles. Reset masks the host grant so a request being discarded never
  // reaches the CSR file, even for the one cycle reset is sampled.
  assign core_wins  = core_csr_valid && (wait_cnt < WAIT_MAX);
  assign host_grant = (state == ARB_PEND) && !reset && !core_wins;

  // Selects who drives the CSR file this cycle.
  function automatic csr_port_t port_mux(
    input logic                      host,
    input host_req_t                 req,
    input logic                      cvalid,
    input logic [CSR_ADDR_WIDTH-1:0] caddr,
    input logic [CSR_CMD_WIDTH-1:0]  ccmd,
    input logic [XPR_LEN-1:0]        cwdata
  );
    csr_port_t p;
    p = CSR_PORT_IDLE;
    if (host) begin
      p.addr  = req.addr;
      p.cmd   = req.rw ? CSR_WRITE : CSR_READ;
      p.wdata = req.data;
    end else if (cvalid) begin
      // SET/CLEAR pass straight through; the CSR file does the RMW.
      p.addr  = caddr;
      p.cmd   = ccmd;
      p.wdata = cwdata;
    end
    return p;
  endfunction

  // NOTE: every signal written in always_comb gets a value on every path
  // (here the whole struct at once), otherwise synthesis infers a latch.
  always_comb begin
    port = CSR_PORT_IDLE;
    port = port_mux(host_grant, req_q, core_csr_valid,
                    core_csr_addr, core_csr_cmd, core_csr_wdata);
  end

  assign csr_addr  = port.addr;
  assign csr_cmd   = port.cmd;
  assign csr_wdata = port.wdata;

  assign core_csr_rdata = csr_rdata;
  assign core_csr_stall = host_grant && core_csr_valid;

  assign htif_pcr_req_ready  = req_ready_q;
  assign htif_pcr_resp_valid = resp_valid_q;
  assign htif_pcr_resp_data  = {{(HTIF_PCR_WIDTH-XPR_LEN){1'b0}}, resp_data_q};

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the latched request and response data are plain registers,
      // so they are cleared here; a stale host word never leaks out.
      state        <= ARB_IDLE;
      wait_cnt     <= '0;
      req_q        <= '0;
      resp_data_q  <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (htif_pcr_req_valid) begin
            req_q.rw    <= htif_pcr_req_rw;
            req_q.addr  <= htif_pcr_req_addr;
            req_q.data  <= htif_pcr_req_data[XPR_LEN-1:0];
            wait_cnt    <= '0;
            req_ready_q <= 1'b0;
            state       <= ARB_PEND;
          end
        end

        ARB_PEND: begin
          if (host_grant) begin
            // For writes this is the value before the write lands.
            resp_data_q  <= csr_rdata;
            wait_cnt     <= '0;
            resp_valid_q <= 1'b1;
            state        <= ARB_RESP;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ARB_RESP: begin
          if (htif_pcr_resp_ready) begin
            resp_valid_q <= 1'b0;
            // Ready rises only in the following IDLE cycle, so a request
            // can never overlap the response handshake.
            req_ready_q  <= 1'b1;
            state        <= ARB_IDLE;
          end
        end

        default: begin
          state        <= ARB_IDLE;
          wait_cnt     <= '0;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_csr_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vscale_csr_port_arbiter
//   Directed bench. Host responses are predicted when each request is
//   issued and queued; a monitor pops and compares whenever a response
//   handshake happens. Port-level behaviour is checked inline.
// ---------------------------------------------------------------------------
module tb_vscale_csr_port_arbiter;
  import vscale_csr_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_csr_valid;
  logic [11:0] core_csr_addr;
  logic [2:0]  core_csr_cmd;
  logic [31:0] core_csr_wdata;
  logic [31:0] core_csr_rdata;
  logic        core_csr_stall;
  logic        htif_pcr_req_valid;
  logic        htif_pcr_req_ready;
  logic        htif_pcr_req_rw;
  logic [11:0] htif_pcr_req_addr;
  logic [63:0] htif_pcr_req_data;
  logic        htif_pcr_resp_valid;
  logic        htif_pcr_resp_ready;
  logic [63:0] htif_pcr_resp_data;
  logic [11:0] csr_addr;
  logic [2:0]  csr_cmd;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  vscale_csr_port_arbiter #(.MAX_WAIT(4), .WAIT_CNT_WIDTH(3)) dut (
    .clk                 (clk),
    .reset               (reset),
    .core_csr_valid      (core_csr_valid),
    .core_csr_addr       (core_csr_addr),
    .core_csr_cmd        (core_csr_cmd),
    .core_csr_wdata      (core_csr_wdata),
    .core_csr_rdata      (core_csr_rdata),
    .core_csr_stall      (core_csr_stall),
    .htif_pcr_req_valid  (htif_pcr_req_valid),
    .htif_pcr_req_ready  (htif_pcr_req_ready),
    .htif_pcr_req_rw     (htif_pcr_req_rw),
    .htif_pcr_req_addr   (htif_pcr_req_addr),
    .htif_pcr_req_data   (htif_pcr_req_data),
    .htif_pcr_resp_valid (htif_pcr_resp_valid),
    .htif_pcr_resp_ready (htif_pcr_resp_ready),
    .htif_pcr_resp_data  (htif_pcr_resp_data),
    .csr_addr            (csr_addr),
    .csr_cmd             (csr_cmd),
    .csr_wdata           (csr_wdata),
    .csr_rdata           (csr_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let freshly driven inputs propagate through the combinational mux.
  task automatic settle();
    #1;
  endtask

  // Response monitor: sampled on the falling edge, away from updates.
  always @(negedge clk) begin
    if (!reset && htif_pcr_resp_valid && htif_pcr_resp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", htif_pcr_resp_data, 64'hx);
      end else begin
        check("resp_data", htif_pcr_resp_data, exp_q.pop_front());
      end
    end
  end

  // Present a host request in an IDLE cycle; on return the DUT is in PEND.
  task automatic issue(input logic rw, input logic [11:0] addr,
                       input logic [63:0] data, input logic [63:0] exp, input logic expect_resp);
    htif_pcr_req_valid = 1'b1;
    htif_pcr_req_rw    = rw;
    htif_pcr_req_addr  = addr;
    htif_pcr_req_data  = data;
    if (expect_resp) exp_q.push_back(exp);
    settle();
    check("req_ready_idle", 64'(htif_pcr_req_ready), 64'd1);
    step();
    htif_pcr_req_valid = 1'b0;
  endtask

  initial begin
    reset               = 1'b1;
    core_csr_valid      = 1'b0;
    core_csr_addr       = '0;
    core_csr_cmd        = CSR_IDLE;
    core_csr_wdata      = '0;
    htif_pcr_req_valid  = 1'b0;
    htif_pcr_req_rw     = 1'b0;
    htif_pcr_req_addr   = '0;
    htif_pcr_req_data   = '0;
    htif_pcr_resp_ready = 1'b1;
    csr_rdata           = '0;
    step();
    step();
    reset = 1'b0;
    settle();
    check("rst_req_ready", 64'(htif_pcr_req_ready), 64'd1);
    check("rst_resp_valid", 64'(htif_pcr_resp_valid), 64'd0);
    check("rst_resp_data", htif_pcr_resp_data, 64'd0);
    check("rst_csr_cmd", 64'(csr_cmd), 64'(CSR_IDLE));

    // 1: uncontended host read
    csr_rdata = 32'h1234;
    issue(1'b0, 12'h780, 64'h0, 64'h0000_0000_0000_1234, 1'b1);
    settle();
    check("rd_req_ready_T1", 64'(htif_pcr_req_ready), 64'd0);
    check("rd_cmd_T1", 64'(csr_cmd), 64'(CSR_READ));
    check("rd_addr_T1", 64'(csr_addr), 64'h780);
    check("rd_stall_T1", 64'(core_csr_stall), 64'd0);
    step();
    check("rd_resp_valid_T2", 64'(htif_pcr_resp_valid), 64'd1);
    step();
    check("rd_back_idle_ready", 64'(htif_pcr_req_ready), 64'd1);
    check("rd_back_idle_valid", 64'(htif_pcr_resp_valid), 64'd0);

    // 2: host write returns the old value
    csr_rdata = 32'h5;
    issue(1'b1, 12'h780, 64'hFFFF_FFFF_DEAD_BEEF, 64'h5, 1'b1);
    settle();
    check("wr_cmd", 64'(csr_cmd), 64'(CSR_WRITE));
    check("wr_wdata", 64'(csr_wdata), 64'hDEAD_BEEF);
    check("wr_addr", 64'(csr_addr), 64'h780);
    step();
    check("wr_cmd_one_cycle", 64'(csr_cmd), 64'(CSR_IDLE));
    check("wr_resp_valid", 64'(htif_pcr_resp_valid), 64'd1);
    step();

    // 3: contention, host forced after MAX_WAIT lost cycles
    core_csr_valid = 1'b1;
    core_csr_cmd   = CSR_SET;
    core_csr_addr  = 12'h300;
    core_csr_wdata = 32'h8;
    csr_rdata      = 32'h111;
    issue(1'b0, 12'h7C0, 64'h0, 64'hABC, 1'b1);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("cont_core_cmd", 64'(csr_cmd), 64'(CSR_SET));
      check("cont_core_stall", 64'(core_csr_stall), 64'd0);
      step();
    end
    csr_rdata = 32'hABC;
    settle();
    check("cont_forced_cmd", 64'(csr_cmd), 64'(CSR_READ));
    check("cont_forced_addr", 64'(csr_addr), 64'h7C0);
    check("cont_forced_stall", 64'(core_csr_stall), 64'd1);
    step();
    csr_rdata = 32'h111;
    settle();
    check("cont_stall_drop", 64'(core_csr_stall), 64'd0);
    check("cont_core_back", 64'(csr_cmd), 64'(CSR_SET));
    step();
    core_csr_valid = 1'b0;
    core_csr_cmd   = CSR_IDLE;

    // 4: host back-pressures the response
    htif_pcr_resp_ready = 1'b0;
    csr_rdata = 32'h77;
    issue(1'b0, 12'h781, 64'h0, 64'h77, 1'b1);
    step();
    csr_rdata      = 32'h99;
    core_csr_valid = 1'b1;
    core_csr_cmd   = CSR_READ;
    core_csr_addr  = 12'h301;
    htif_pcr_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("hold_resp_valid", 64'(htif_pcr_resp_valid), 64'd1);
      check("hold_resp_data", htif_pcr_resp_data, 64'h77);
      check("hold_req_ready", 64'(htif_pcr_req_ready), 64'd0);
      check("hold_core_stall", 64'(core_csr_stall), 64'd0);
      check("hold_core_addr", 64'(csr_addr), 64'h301);
      check("hold_core_rdata", 64'(core_csr_rdata), 64'h99);
      step();
    end
    htif_pcr_req_valid  = 1'b0;
    core_csr_valid      = 1'b0;
    core_csr_cmd        = CSR_IDLE;
    htif_pcr_resp_ready = 1'b1;
    step();
    step();

    // 5: reset during PEND discards the request
    issue(1'b1, 12'h782, 64'h1, 64'h0, 1'b0);
    reset = 1'b1;
    settle();
    check("rstp_no_write", 64'(csr_cmd), 64'(CSR_IDLE));
    step();
    reset = 1'b0;
    settle();
    check("rstp_req_ready", 64'(htif_pcr_req_ready), 64'd1);
    check("rstp_resp_valid", 64'(htif_pcr_resp_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstp_no_resp", 64'(htif_pcr_resp_valid), 64'd0);
      check("rstp_cmd_idle", 64'(csr_cmd), 64'(CSR_IDLE));
    end

    // 6: back-to-back host requests
    csr_rdata = 32'h1111;
    exp_q.push_back(64'h1111);
    exp_q.push_back(64'h2222);
    htif_pcr_req_valid = 1'b1;
    htif_pcr_req_rw    = 1'b0;
    htif_pcr_req_addr  = 12'h790;
    settle();
    check("b2b_accept_a", 64'(htif_pcr_req_ready), 64'd1);
    step();                                   // PEND for A
    htif_pcr_req_addr = 12'h791;              // B held valid from here on
    settle();
    check("b2b_addr_a", 64'(csr_addr), 64'h790);
    step();                                   // RESP for A, handshake
    settle();
    check("b2b_no_overlap", 64'(htif_pcr_req_ready), 64'd0);
    step();                                   // IDLE, accepts B
    csr_rdata = 32'h2222;
    settle();
    check("b2b_accept_b", 64'(htif_pcr_req_ready), 64'd1);
    step();                                   // PEND for B
    htif_pcr_req_valid = 1'b0;
    settle();
    check("b2b_addr_b", 64'(csr_addr), 64'h791);
    step();                                   // RESP for B
    step();

    // Drain any outstanding predictions within a bounded window.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    check("drain_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
